// File: rtl/native_mem_arbiter_if.sv
// PicoRV32-style native memory port: valid/ready handshake with a 32-bit
// address and data path, byte strobes and an instruction-fetch flag.
interface native_mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/native_mem_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory bus. Transactions are
// serialised onto one slave, with a response timeout that aborts with ERR_RDATA.
module native_mem_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  native_mem_arbiter_if.slave  m0,
  native_mem_arbiter_if.slave  m1,
  native_mem_arbiter_if.master s,
  output logic                 grant,
  output logic                 busy,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit          TO_EN     = (TIMEOUT != 0);
  localparam int unsigned TO_LAST   = TO_EN ? TIMEOUT - 1 : 0;
  localparam logic [15:0] TO_LAST_W = 16'(TO_LAST);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        winner;
  logic        expire;
  logic [31:0] resp_data;

  // On contention the round-robin mode favours whoever was not granted last.
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ROUND_ROBIN ? ~last : 1'b0;
    return v1;
  endfunction

  assign winner    = pick(m0.valid, m1.valid, grant);
  assign expire    = TO_EN && (wait_cnt == TO_LAST_W);
  assign resp_data = s.ready ? s.rdata : ERR_RDATA;

  // Abort is flagged in the expiring BUSY cycle itself; a same-cycle s_ready wins.
  assign timeout_err = (state == BUSY) && expire && !s.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      grant    <= 1'b1;
      busy     <= 1'b0;
      s.valid  <= 1'b0;
      s.instr  <= 1'b0;
      s.addr   <= '0;
      s.wdata  <= '0;
      s.wstrb  <= '0;
      m0.ready <= 1'b0;
      m1.ready <= 1'b0;
      m0.rdata <= '0;
      m1.rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0.valid || m1.valid) begin
            grant    <= winner;
            busy     <= 1'b1;
            s.valid  <= 1'b1;
            wait_cnt <= '0;
            s.instr  <= winner ? m1.instr : m0.instr;
            s.addr   <= winner ? m1.addr  : m0.addr;
            s.wdata  <= winner ? m1.wdata : m0.wdata;
            s.wstrb  <= winner ? m1.wstrb : m0.wstrb;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (s.ready || expire) begin
            s.valid <= 1'b0;
            if (grant) begin
              m1.rdata <= resp_data;
              m1.ready <= 1'b1;
            end else begin
              m0.rdata <= resp_data;
              m0.ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          m0.ready <= 1'b0;
          m1.ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_native_mem_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share one stimulus stream
// and are compared every cycle against a transaction-level model.
module tb_native_mem_arbiter;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        zero_wait, s_ready_man;
  logic [31:0] s_rdata;
  logic        s_ready_w;
  logic        grant_a, busy_a, to_a, grant_b, busy_b, to_b;

  native_mem_arbiter_if ma0 ();
  native_mem_arbiter_if ma1 ();
  native_mem_arbiter_if sa ();
  native_mem_arbiter_if mb0 ();
  native_mem_arbiter_if mb1 ();
  native_mem_arbiter_if sb ();

  always #5 clk = ~clk;

  assign ma0.valid = m0_valid;  assign mb0.valid = m0_valid;
  assign ma0.instr = m0_instr;  assign mb0.instr = m0_instr;
  assign ma0.addr  = m0_addr;   assign mb0.addr  = m0_addr;
  assign ma0.wdata = m0_wdata;  assign mb0.wdata = m0_wdata;
  assign ma0.wstrb = m0_wstrb;  assign mb0.wstrb = m0_wstrb;
  assign ma1.valid = m1_valid;  assign mb1.valid = m1_valid;
  assign ma1.instr = m1_instr;  assign mb1.instr = m1_instr;
  assign ma1.addr  = m1_addr;   assign mb1.addr  = m1_addr;
  assign ma1.wdata = m1_wdata;  assign mb1.wdata = m1_wdata;
  assign ma1.wstrb = m1_wstrb;  assign mb1.wstrb = m1_wstrb;

  // Slave timing does not depend on which master won, so both instances share it.
  assign s_ready_w = zero_wait ? sa.valid : s_ready_man;
  assign sa.ready  = s_ready_w;  assign sb.ready = s_ready_w;
  assign sa.rdata  = s_rdata;    assign sb.rdata = s_rdata;

  native_mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO), .ERR_RDATA(ERR)) dut_a (
    .clk(clk), .reset(rst), .m0(ma0), .m1(ma1), .s(sa),
    .grant(grant_a), .busy(busy_a), .timeout_err(to_a)
  );

  native_mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO), .ERR_RDATA(ERR)) dut_b (
    .clk(clk), .reset(rst), .m0(mb0), .m1(mb1), .s(sb),
    .grant(grant_b), .busy(busy_b), .timeout_err(to_b)
  );

  // Model per instance: ph 0 = no transaction, 1 = waiting on slave, 2 = answering master.
  int          ph[2];
  int          nbusy[2];
  logic        own[2];
  req_t        fwd[2];
  logic [31:0] rd[2][2];
  bit          chk_en = 1'b0;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, sv_cnt = 0, to_cnt = 0, r0_cnt = 0, r1_cnt = 0, to_cyc = 0, r1_cyc = 0;
  logic glog_a[$];
  logic glog_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_req(input int m, input logic v, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    if (m == 0) begin
      m0_valid = v; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_valid = v; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
  endtask

  task automatic model_step(input int i);
    req_t r0, r1;
    logic w;
    r0 = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
    r1 = {m1_instr, m1_addr, m1_wdata, m1_wstrb};
    if (rst) begin
      ph[i] = 0; nbusy[i] = 0; own[i] = 1'b1; fwd[i] = '0; rd[i][0] = '0; rd[i][1] = '0;
    end else if (ph[i] == 2) begin
      ph[i] = 0;
    end else if (ph[i] == 1) begin
      if (s_ready_w) begin
        rd[i][own[i]] = s_rdata; ph[i] = 2;
      end else if (nbusy[i] + 1 == TO) begin
        rd[i][own[i]] = ERR; ph[i] = 2;
      end else begin
        nbusy[i]++;
      end
    end else if (m0_valid || m1_valid) begin
      if (m0_valid && m1_valid) w = (i == 0) ? ~own[i] : 1'b0;
      else w = m1_valid;
      own[i] = w; fwd[i] = w ? r1 : r0; ph[i] = 1; nbusy[i] = 0;
    end
  endtask

  task automatic cmp(input int i, input logic sv, input logic si, input logic [31:0] sad,
                     input logic [31:0] swd, input logic [3:0] sws, input logic g, input logic b,
                     input logic te, input logic r0, input logic r1, input logic [31:0] d0,
                     input logic [31:0] d1);
    string p;
    logic  exp_te;
    p = (i == 0) ? "A." : "B.";
    exp_te = (ph[i] == 1) && (nbusy[i] + 1 == TO) && !s_ready_w;
    chk({p, "s_valid"},     32'(sv),  32'(ph[i] == 1));
    chk({p, "s_instr"},     32'(si),  32'(fwd[i].instr));
    chk({p, "s_addr"},      sad,      fwd[i].addr);
    chk({p, "s_wdata"},     swd,      fwd[i].wdata);
    chk({p, "s_wstrb"},     32'(sws), 32'(fwd[i].wstrb));
    chk({p, "grant"},       32'(g),   32'(own[i]));
    chk({p, "busy"},        32'(b),   32'(ph[i] != 0));
    chk({p, "timeout_err"}, 32'(te),  32'(exp_te));
    chk({p, "m0_ready"},    32'(r0),  32'(ph[i] == 2 && own[i] == 1'b0));
    chk({p, "m1_ready"},    32'(r1),  32'(ph[i] == 2 && own[i] == 1'b1));
    chk({p, "m0_rdata"},    d0,       rd[i][0]);
    chk({p, "m1_rdata"},    d1,       rd[i][1]);
  endtask

  // One clock: compare at the falling edge, advance the model, resume just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      cmp(0, sa.valid, sa.instr, sa.addr, sa.wdata, sa.wstrb, grant_a, busy_a, to_a,
          ma0.ready, ma1.ready, ma0.rdata, ma1.rdata);
      cmp(1, sb.valid, sb.instr, sb.addr, sb.wdata, sb.wstrb, grant_b, busy_b, to_b,
          mb0.ready, mb1.ready, mb0.rdata, mb1.rdata);
    end
    cyc++;
    if (sa.valid === 1'b1) sv_cnt++;
    if (to_a === 1'b1) begin to_cnt++; to_cyc = cyc; end
    if (ma0.ready === 1'b1) begin r0_cnt++; glog_a.push_back(1'b0); end
    if (ma1.ready === 1'b1) begin r1_cnt++; r1_cyc = cyc; glog_a.push_back(1'b1); end
    if (mb0.ready === 1'b1) glog_b.push_back(1'b0);
    if (mb1.ready === 1'b1) glog_b.push_back(1'b1);
    model_step(0);
    model_step(1);
    if (rst) chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int m, input logic instr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input int waits,
                     input logic [31:0] data);
    int   n;
    logic got;
    set_req(m, 1'b1, instr, addr, wdata, wstrb);
    n = 0;
    while (sa.valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("txn_start", 32'(sa.valid), 32'd1);
    if (waits >= 0) begin
      repeat (waits) tick();
      s_ready_man = 1'b1;
      s_rdata     = data;
      tick();
      s_ready_man = 1'b0;
    end
    n   = 0;
    got = (m == 0) ? ma0.ready : ma1.ready;
    while (got !== 1'b1 && n < 20) begin
      tick(); n++;
      got = (m == 0) ? ma0.ready : ma1.ready;
    end
    chk("txn_ready", 32'(got), 32'd1);
    tick();
    set_req(m, 1'b0, instr, addr, wdata, wstrb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         s0, t0, a0, b0, qa, qb;
    logic [2:0] exp3;
    rst = 1'b1; zero_wait = 1'b0; s_ready_man = 1'b0; s_rdata = '0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    chk("reset_grant", 32'(grant_a), 32'd1);
    chk("reset_s_valid", 32'(sa.valid), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    tick();

    // Single instruction read with two wait states.
    s0 = sv_cnt; a0 = r0_cnt; b0 = r1_cnt;
    txn(0, 1'b1, 32'h100, 32'h0, 4'b0000, 2, 32'hCAFE_F00D);
    chk("read_svalid_cycles", 32'(sv_cnt - s0), 32'd3);
    chk("read_m0_rdata", ma0.rdata, 32'hCAFE_F00D);
    chk("read_m0_ready_pulses", 32'(r0_cnt - a0), 32'd1);
    chk("read_m1_ready_pulses", 32'(r1_cnt - b0), 32'd0);
    tick();

    // Continuous contention with a zero-wait slave.
    rst = 1'b1; tick(); rst = 1'b0;
    qa = glog_a.size(); qb = glog_b.size(); a0 = r0_cnt; b0 = r1_cnt;
    zero_wait = 1'b1; s_rdata = 32'h5555_AAAA;
    set_req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'b0000);
    set_req(1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'b0000);
    repeat (12) tick();
    set_req(0, 1'b0, 1'b0, 32'h1000, 32'h0, 4'b0000);
    set_req(1, 1'b0, 1'b0, 32'h2000, 32'h0, 4'b0000);
    zero_wait = 1'b0;
    tick();
    chk("rr_completions", 32'(glog_a.size() - qa), 32'd4);
    chk("fp_completions", 32'(glog_b.size() - qb), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (qa + k < glog_a.size())
        chk($sformatf("rr_owner%0d", k), 32'(glog_a[qa + k]), 32'(k % 2));
      if (qb + k < glog_b.size())
        chk($sformatf("fp_owner%0d", k), 32'(glog_b[qb + k]), 32'd0);
    end
    chk("rr_m0_pulses", 32'(r0_cnt - a0), 32'd2);
    chk("rr_m1_pulses", 32'(r1_cnt - b0), 32'd2);

    // Fixed priority hands over to m1 once m0 releases its request.
    rst = 1'b1; tick(); rst = 1'b0;
    qa = glog_a.size(); qb = glog_b.size();
    zero_wait = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h1100, 32'h0, 4'b0000);
    set_req(1, 1'b1, 1'b1, 32'h2200, 32'h0, 4'b0000);
    repeat (6) tick();
    set_req(0, 1'b0, 1'b0, 32'h1100, 32'h0, 4'b0000);
    repeat (3) tick();
    set_req(1, 1'b0, 1'b1, 32'h2200, 32'h0, 4'b0000);
    zero_wait = 1'b0;
    tick();
    chk("fp2_completions", 32'(glog_b.size() - qb), 32'd3);
    chk("rr2_completions", 32'(glog_a.size() - qa), 32'd3);
    exp3 = 3'b100;
    for (int k = 0; k < 3; k++)
      if (qb + k < glog_b.size())
        chk($sformatf("fp2_owner%0d", k), 32'(glog_b[qb + k]), 32'(exp3[k]));
    exp3 = 3'b110;
    for (int k = 0; k < 3; k++)
      if (qa + k < glog_a.size())
        chk($sformatf("rr2_owner%0d", k), 32'(glog_a[qa + k]), 32'(exp3[k]));

    // Dead slave: abort after exactly TO cycles.
    s0 = sv_cnt; t0 = to_cnt;
    txn(1, 1'b0, 32'h300, 32'h0, 4'b0000, -1, 32'h0);
    chk("to_svalid_cycles", 32'(sv_cnt - s0), 32'd4);
    chk("to_err_pulses", 32'(to_cnt - t0), 32'd1);
    chk("to_ready_after_err", 32'(r1_cyc - to_cyc), 32'd1);
    chk("to_m1_rdata", ma1.rdata, ERR);

    // s_ready on the expiring cycle is a normal completion.
    s0 = sv_cnt; t0 = to_cnt;
    txn(1, 1'b0, 32'h304, 32'h0, 4'b0000, 3, 32'h0BAD_BEEF);
    chk("late_svalid_cycles", 32'(sv_cnt - s0), 32'd4);
    chk("late_err_pulses", 32'(to_cnt - t0), 32'd0);
    chk("late_m1_rdata", ma1.rdata, 32'h0BAD_BEEF);

    // Write forwarding from m1.
    txn(1, 1'b0, 32'h2004, 32'h1234_5678, 4'b0110, 2, 32'hDEAD_0000);
    chk("wr_s_addr", sa.addr, 32'h2004);
    chk("wr_s_wdata", sa.wdata, 32'h1234_5678);
    chk("wr_s_wstrb", 32'(sa.wstrb), 32'h6);
    chk("wr_s_instr", 32'(sa.instr), 32'd0);
    tick();

    // Reset two cycles into a transaction drops it silently.
    a0 = r0_cnt; b0 = r1_cnt;
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'b0000);
    s0 = 0;
    while (sa.valid !== 1'b1 && s0 < 20) begin tick(); s0++; end
    chk("rst_txn_start", 32'(sa.valid), 32'd1);
    chk("rst_txn_grant", 32'(grant_a), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h400, 32'h0, 4'b0000);
    chk("rst_mid_s_valid", 32'(sa.valid), 32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_grant", 32'(grant_a), 32'd1);
    chk("rst_mid_m1_rdata", ma1.rdata, 32'h0);
    s_ready_man = 1'b1; s_rdata = 32'h7777_7777;
    repeat (2) tick();
    s_ready_man = 1'b0;
    tick();
    chk("rst_no_m0_ready", 32'(r0_cnt - a0), 32'd0);
    chk("rst_no_m1_ready", 32'(r1_cnt - b0), 32'd0);
    chk("rst_spurious_busy", 32'(busy_a), 32'd0);
    chk("rst_spurious_m0_rdata", ma0.rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
